// File: rtl/seg_pkg.sv
//============================================================================
// seg_pkg: segment codes, FSM state type and BCD sizing helper. Rev 1.0
//============================================================================
`default_nettype none

package seg_pkg;

  // {a,b,c,d,e,f,g,bit0}, active low
  localparam logic [7:0] C_SEG_0     = 8'b00000010;
  localparam logic [7:0] C_SEG_1     = 8'b10011110;
  localparam logic [7:0] C_SEG_2     = 8'b00100100;
  localparam logic [7:0] C_SEG_3     = 8'b00001100;
  localparam logic [7:0] C_SEG_4     = 8'b10011000;
  localparam logic [7:0] C_SEG_5     = 8'b01001000;
  localparam logic [7:0] C_SEG_6     = 8'b01000000;
  localparam logic [7:0] C_SEG_7     = 8'b00011110;
  localparam logic [7:0] C_SEG_8     = 8'b00000000;
  localparam logic [7:0] C_SEG_9     = 8'b00001000;
  localparam logic [7:0] C_SEG_DASH  = 8'b11111100;
  localparam logic [7:0] C_SEG_BLANK = 8'b11111110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // ceil(width*0.302)+1 digits always holds 2^width-1
  function automatic int calc_nb(input int width);
    return (width * 302 + 999) / 1000 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
//============================================================================
// seg_decode: BCD digit plus blank/dash flags -> active-low segment code. Rev 1.0
//============================================================================
`default_nettype none

module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = C_SEG_BLANK;
    if (i_dash) begin
      o_seg = C_SEG_DASH;
    end else if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = C_SEG_0;
        4'd1:    o_seg = C_SEG_1;
        4'd2:    o_seg = C_SEG_2;
        4'd3:    o_seg = C_SEG_3;
        4'd4:    o_seg = C_SEG_4;
        4'd5:    o_seg = C_SEG_5;
        4'd6:    o_seg = C_SEG_6;
        4'd7:    o_seg = C_SEG_7;
        4'd8:    o_seg = C_SEG_8;
        4'd9:    o_seg = C_SEG_9;
        default: o_seg = C_SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
//============================================================================
// seg_scan_driver: double-dabble BCD converter + multiplexed 7-seg scan.
// Define SEG_BLANK_EN for leading-zero blanking. Rev 1.0
//============================================================================
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int NB    = calc_nb(WIDTH);
  localparam int NACC  = (NB > DIGITS) ? NB : DIGITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [4*NACC-1:0]     acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  disp_ovf_q, disp_ovf_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  acc_hi_nz;
  logic [DIGITS-1:0]     blank_vec;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [7:0]            seg_dec;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NACC; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    acc_hi_nz = 1'b0;
    for (int i = DIGITS; i < NACC; i++) acc_hi_nz = acc_hi_nz | (acc_q[4*i +: 4] != 4'd0);
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = CONVERT;
          shift_d = value;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        acc_d   = {acc_adj[4*NACC-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      UPDATE: begin
        state_d    = IDLE;
        bcd_d      = acc_q[4*DIGITS-1:0];
        ovf_d      = acc_hi_nz;
        disp_d     = acc_q[4*DIGITS-1:0];
        disp_ovf_d = acc_hi_nz;
        done_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scan timing is free-running; only the latch contents follow conversions.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PS_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEG_BLANK_EN
  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero    = lead_zero & (disp_q[4*i +: 4] == 4'd0);
      blank_vec[i] = lead_zero & (i != 0);
    end
  end
`else
  assign blank_vec = '0;
`endif

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_blank = blank_vec[i];
      end
    end
  end

  seg_decode u_seg_decode (
    .i_digit (cur_digit),
    .i_blank (cur_blank),
    .i_dash  (disp_ovf_q),
    .o_seg   (seg_dec)
  );

  always_comb begin
    seg_d = seg_dec;
    an_d  = '1;
    for (int i = 0; i < DIGITS; i++) an_d[i] = (idx_q != IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= C_SEG_0;
      an_q       <= AN_RST;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
//============================================================================
// tb_seg_scan_driver: table-driven vectors with a done-scoreboard for two
// configurations (3 and 2 digits, SCAN_DIV=4). Rev 1.0
//============================================================================
`default_nettype none

module tb_seg_scan_driver;

  typedef struct {
    logic [7:0]  value;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load1, load2;
  logic [7:0]  value1, value2;
  logic        busy1, done1, ovf1, busy2, done2, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;
  logic [7:0]  seg1, seg2;
  logic [2:0]  an1;
  logic [1:0]  an2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_driver #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .value(value1), .busy(busy1),
    .done(done1), .ovf(ovf1), .bcd(bcd1), .seg(seg1), .an(an1)
  );

  seg_scan_driver #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .value(value2), .busy(busy2),
    .done(done2), .ovf(ovf2), .bcd(bcd2), .seg(seg2), .an(an2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 8'b00000010;
      4'd1: return 8'b10011110;
      4'd2: return 8'b00100100;
      4'd3: return 8'b00001100;
      4'd4: return 8'b10011000;
      4'd5: return 8'b01001000;
      4'd6: return 8'b01000000;
      4'd7: return 8'b00011110;
      4'd8: return 8'b00000000;
      4'd9: return 8'b00001000;
      default: return 8'b11111110;
    endcase
  endfunction

  // Scoreboard: every done pops one expectation, including its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("d1_spurious_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("d1_bcd", 32'(bcd1), 32'(e.bcd));
        chk("d1_ovf", 32'(ovf1), 32'(e.ovf));
        chk("d1_latency", cyc, e.due);
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) chk("d2_spurious_done", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("d2_bcd", 32'(bcd2), 32'(e.bcd[7:0]));
        chk("d2_ovf", 32'(ovf2), 32'(e.ovf));
        chk("d2_latency", cyc, e.due);
      end
    end
  end

  task automatic load_1(input logic [7:0] v, input logic [11:0] eb, input logic eo);
    @(negedge clk);
    load1 = 1'b1;
    value1 = v;
    q1.push_back('{eb, eo, cyc + 10});
    @(negedge clk);
    load1 = 1'b0;
    value1 = ~v;
  endtask

  task automatic load_2(input logic [7:0] v, input logic [11:0] eb, input logic eo);
    @(negedge clk);
    load2 = 1'b1;
    value2 = v;
    q2.push_back('{eb, eo, cyc + 10});
    @(negedge clk);
    load2 = 1'b0;
    value2 = ~v;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 0) ? (q1.size() != 0 || busy1) : (q2.size() != 0 || busy2)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("done_timeout", 32'(n), 32'd0);
      if (which == 0) q1.delete(); else q2.delete();
    end
    @(negedge clk);
  endtask

  task automatic scan_check(input int which, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic dash, input int ncyc);
    logic [3:0] dg[3];
    logic [7:0] a, s, es;
    int nd, zeros, idx, prev, run;
    bit started, blank;
    dg[0] = d0; dg[1] = d1; dg[2] = d2;
    nd = (which == 0) ? 3 : 2;
    prev = -1; run = 0; started = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      a = (which == 0) ? {5'b11111, an1} : {6'b111111, an2};
      s = (which == 0) ? seg1 : seg2;
      zeros = 0; idx = 0;
      for (int k = 0; k < nd; k++) if (a[k] == 1'b0) begin zeros++; idx = k; end
      chk("an_onehot_low", 32'(zeros), 32'd1);
      blank = 0;
`ifdef SEG_BLANK_EN
      blank = (idx != 0);
      for (int j = idx; j < nd; j++) if (dg[j] != 4'd0) blank = 0;
`endif
      es = dash ? 8'b11111100 : (blank ? 8'b11111110 : seg_code(dg[idx]));
      chk("seg_digit", 32'(s), 32'(es));
      if (idx == prev) run++;
      else begin
        if (prev >= 0) begin
          if (started) chk("dwell", 32'(run), 32'd4);
          chk("scan_order", 32'(idx), 32'((prev + 1) % nd));
          started = 1;
        end
        prev = idx;
        run = 1;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t1[7];
    vec_t t2[5];
    int n;
    t1[0] = '{8'd255, 12'h255, 1'b0};
    t1[1] = '{8'd0,   12'h000, 1'b0};
    t1[2] = '{8'd7,   12'h007, 1'b0};
    t1[3] = '{8'd99,  12'h099, 1'b0};
    t1[4] = '{8'd128, 12'h128, 1'b0};
    t1[5] = '{8'd200, 12'h200, 1'b0};
    t1[6] = '{8'd10,  12'h010, 1'b0};
    t2[0] = '{8'd100, 12'h000, 1'b1};
    t2[1] = '{8'd42,  12'h042, 1'b0};
    t2[2] = '{8'd255, 12'h055, 1'b1};
    t2[3] = '{8'd99,  12'h099, 1'b0};
    t2[4] = '{8'd0,   12'h000, 1'b0};

    rst_n = 1'b0; load1 = 1'b0; load2 = 1'b0; value1 = 8'd0; value2 = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_bcd", 32'(bcd1), 32'd0);
    chk("rst_an", 32'(an1), 32'b110);
    chk("rst_seg", 32'(seg1), 32'b00000010);
    chk("rst_an2", 32'(an2), 32'b10);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_seg", 32'(seg1), 32'b00000010);

    for (int i = 0; i < 7; i++) begin
      load_1(t1[i].value, t1[i].bcd, t1[i].ovf);
      chk("busy_during_conv", 32'(busy1), 32'd1);
      drain(0);
    end
    for (int i = 0; i < 5; i++) begin
      load_2(t2[i].value, t2[i].bcd, t2[i].ovf);
      drain(1);
    end

    load_1(8'd255, 12'h255, 1'b0);
    drain(0);
    scan_check(0, 4'd5, 4'd5, 4'd2, 1'b0, 30);
    load_1(8'd0, 12'h000, 1'b0);
    drain(0);
    scan_check(0, 4'd0, 4'd0, 4'd0, 1'b0, 14);

    load_2(8'd100, 12'h000, 1'b1);
    drain(1);
    scan_check(1, 4'd0, 4'd0, 4'd0, 1'b1, 12);
    load_2(8'd42, 12'h042, 1'b0);
    drain(1);
    scan_check(1, 4'd2, 4'd4, 4'd0, 1'b0, 12);

    // Second load three cycles into a conversion must be dropped.
    load_1(8'd123, 12'h123, 1'b0);
    repeat (2) @(negedge clk);
    load1 = 1'b1; value1 = 8'd45;
    @(negedge clk);
    load1 = 1'b0;
    drain(0);
    repeat (12) @(negedge clk);

    // Reset during iteration 4 aborts the conversion with no done.
    load_1(8'd200, 12'h200, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_bcd", 32'(bcd1), 32'd0);
    chk("abort_an", 32'(an1), 32'b110);
    chk("abort_seg", 32'(seg1), 32'b00000010);
    chk("abort_bcd2", 32'(bcd2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    load_1(8'd37, 12'h037, 1'b0);
    drain(0);

    // Load in the same cycle done is high is accepted.
    load_1(8'd11, 12'h011, 1'b0);
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(done1), 32'd1);
    load1 = 1'b1; value1 = 8'd222;
    q1.push_back('{12'h222, 1'b0, cyc + 10});
    @(negedge clk);
    load1 = 1'b0;
    chk("b2b_accepted_busy", 32'(busy1), 32'd1);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
